// File: rtl/board_pkg.sv
// Board-wide constants and shared helpers for the audio output path.
package board_pkg;

  localparam int AUDIO_STROBE_N = 3;
  localparam int AUDIO_STROBE_M = 2500;
  localparam int AUDIO_WIN_LOG2 = 9;

  localparam int PHASE_W = 12;

  // State carried from the window close (strobe edge) into the DC blocker.
  typedef struct packed {
    logic               valid;
    logic               quiet;
    logic signed [15:0] avg;
  } audio_stage1_t;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7fff;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/audio_frac_strobe.sv
// Resettable fractional strobe generator: exactly N single-cycle pulses every M clocks.
module audio_frac_strobe
  import board_pkg::*;
#(
  parameter int N = AUDIO_STROBE_N,
  parameter int M = AUDIO_STROBE_M
) (
  input  logic clk,
  input  logic reset_n,
  output logic strobe
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   phase_sum;

  assign phase_sum = {1'b0, phase} + (PHASE_W+1)'(N);
  assign strobe    = (phase_sum >= (PHASE_W+1)'(M));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (strobe) begin
      phase <= PHASE_W'(phase_sum - (PHASE_W+1)'(M));
    end else begin
      phase <= phase_sum[PHASE_W-1:0];
    end
  end

endmodule

// File: rtl/audio_out_stage.sv
// Audio output stage: windowed-average decimation to 48 kHz, optional DC blocker,
// 6 dB-step volume and 16-bit saturation, presented as a duplicated stereo pair.
module audio_out_stage
  import board_pkg::*;
#(
  parameter int STROBE_N = AUDIO_STROBE_N,
  parameter int STROBE_M = AUDIO_STROBE_M,
  parameter int WIN_LOG2 = AUDIO_WIN_LOG2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [15:0] sample_in,
  input  logic               paused,
  input  logic               mute,
  input  logic               dc_block_en,
  input  logic [2:0]         volume,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               sample_valid,
  output logic               clip
);

  localparam int ACC_W = 16 + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(1 << WIN_LOG2);

  if ((1 << WIN_LOG2) > (STROBE_M / STROBE_N)) begin : g_bad_window
    $error("averaging window is longer than the strobe spacing");
  end

  logic                    strobe;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  audio_stage1_t           s1;
  logic signed [17:0]      x1;
  logic signed [17:0]      y1;
  logic signed [18:0]      dc_y;
  logic signed [18:0]      y2;
  logic                    s2_valid;
  logic signed [18:0]      vol_v;
  logic signed [15:0]      vol_sat;
  logic                    vol_clip;

  function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
    if (v[18] != v[17]) begin
      return v[18] ? 18'sh20000 : 18'sh1ffff;
    end else begin
      return v[17:0];
    end
  endfunction

  audio_frac_strobe #(
    .N (STROBE_N),
    .M (STROBE_M)
  ) u_strobe (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (strobe)
  );

  // Window opens on the strobe edge and freezes once full, so acc is complete
  // by the time the next strobe closes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (strobe) begin
      acc <= '0;
      cnt <= '0;
    end else if (cnt < WIN_LEN) begin
      acc <= acc + ACC_W'(sample_in);
      cnt <= cnt + 1'b1;
    end
  end

  // The slice equals acc >>> WIN_LOG2: a full window of 16-bit samples always fits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
    end else begin
      s1.valid <= strobe;
      if (strobe) begin
        s1.quiet <= paused | mute;
        s1.avg   <= (paused | mute) ? '0 : acc[WIN_LOG2 +: 16];
      end
    end
  end

  assign dc_y = 19'($signed(s1.avg)) - 19'(x1) + 19'(y1) - 19'(y1 >>> 8);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x1       <= '0;
      y1       <= '0;
      y2       <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1.valid;
      if (s1.valid) begin
        if (dc_block_en && !s1.quiet) begin
          y2 <= dc_y;
          y1 <= sat18(dc_y);
          x1 <= 18'($signed(s1.avg));
        end else begin
          y2 <= 19'($signed(s1.avg));
          x1 <= '0;
          y1 <= '0;
        end
      end
    end
  end

  assign vol_v    = y2 >>> volume;
  assign vol_sat  = sat16(32'(vol_v));
  assign vol_clip = (19'(vol_sat) != vol_v);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
    end else begin
      sample_valid <= s2_valid;
      clip         <= s2_valid & vol_clip;
      if (s2_valid) begin
        audio_l <= vol_sat;
        audio_r <= vol_sat;
      end
    end
  end

endmodule
